// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular FIFO of {instruction, pc} pairs between Fetch
// and Decode, with valid/ready handshakes on both sides and a flush that
// discards wrong-path entries after a taken branch.
// Optional build macro: FDQ_BUBBLE_NOP_EN - when defined, an empty queue
// presents ORR XZR,XZR,XZR with pc 0 instead of the stale slot contents.
module fetch_decode_queue #(
  parameter int INSTR_W = 32,
  parameter int WORD_W  = 64,
  parameter int DEPTH   = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic [WORD_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [WORD_W-1:0]  out_pc,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]     ONE_COUNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]   ONE_PTR    = PTR_W'(1);
`ifdef FDQ_BUBBLE_NOP_EN
  localparam logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(32'hAA1F03FF);
`endif

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  // Handshake qualifiers; in_ready depends only on registered count, so
  // there is no combinational path from out_ready back to Fetch.
  always_comb begin
    in_ready  = (count != FULL_COUNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Entry storage: written at the tail on every accepted push.
  // NOTE: storage arrays carry no reset; emptiness is tracked by count and
  // the pointers, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointer and occupancy update; reset outranks flush, flush outranks
  // any same-cycle push or pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Head entry read combinationally; empty-queue value depends on build.
  // NOTE: both outputs are assigned on every path so no latch is inferred.
  always_comb begin
    out_instruction = instr_mem[rd_ptr];
    out_pc          = pc_mem[rd_ptr];
`ifdef FDQ_BUBBLE_NOP_EN
    if (count == '0) begin
      out_instruction = NOP_INSTR;
      out_pc          = '0;
    end
`else
    // Empty queue shows the stale slot; consumers qualify with out_valid.
`endif
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction queue between the Fetch stage and the Decode stage of the LEGv8 core.
- Buffers {instruction, pc} pairs in a DEPTH-entry circular FIFO with valid/ready handshakes on both sides.
- Lets Fetch run ahead of Decode, and absorbs Decode stalls.
- On a taken branch (pc_src), a flush input discards all wrong-path entries.

Parameters:
- INSTR_W, 32, instruction width in bits (matches INSTR_LEN).
- WORD_W, 64, pc width in bits (matches WORD).
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (driven by pc_src).
- in_valid  input  1  Fetch presents a valid instruction.
- in_ready  output  1  queue can accept an entry this cycle.
- in_instruction  input  INSTR_W  fetched instruction.
- in_pc  input  WORD_W  pc of the fetched instruction.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  Decode consumes the head entry this cycle.
- out_instruction  output  INSTR_W  head instruction.
- out_pc  output  WORD_W  head pc.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Storage is two arrays (instr, pc) indexed by wr_ptr and rd_ptr, each PTR_W bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count is a separate registered counter, not derived from the pointers.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH).
  - Depends only on registered state, with no combinational path from out_ready.
  - When full, simultaneous push and pop cannot occur.
- out_valid = (count != 0).
- out_instruction and out_pc read the head entry combinationally.
- Latency: an entry pushed at edge N is visible at the output after edge N; there is no same-cycle bypass when empty.
- Counter update per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together (0 < count < DEPTH): count unchanged; both pointers advance.
- Ordering: strict FIFO; pc order at the output equals acceptance order.
- Flush (highest priority after reset):
  - count, wr_ptr and rd_ptr all go to 0.
  - A same-cycle push is dropped and a same-cycle pop is ignored.
  - On the next cycle out_valid=0 and in_ready=1.
- Reset:
  - Takes priority over flush.
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - Storage arrays are not cleared.
  - Reset asserted mid-stream discards all contents exactly as flush does.
- Output stability:
  - While out_valid=1 and out_ready=0, out_instruction and out_pc are held.
  - A push into a non-empty queue never alters the head entry.
- When empty, the out_instruction/out_pc value is defined by the optional feature below.
- in_valid while in_ready=0: no effect; Fetch must hold its data.

Optional Feature:
- Macro: FDQ_BUBBLE_NOP_EN.
- Defined:
  - When count==0, out_instruction = 32'hAA1F03FF (ORR XZR,XZR,XZR) and out_pc = 0.
  - Decode therefore always sees a harmless bubble.
- Undefined:
  - When count==0, out_instruction/out_pc show the stale entry at rd_ptr (don't-care).
  - Consumers must qualify with out_valid.
- All other behaviour is identical in both builds.

Test Plan:
- Basic flow:
  - Stimulus: reset 1 cycle, then push instr 0x8B020020 pc 0x0 with out_ready=0.
  - Response: next cycle out_valid=1, out_instruction=0x8B020020, out_pc=0, count=1.
- Fill:
  - Stimulus: out_ready=0, push pcs 0x0, 0x4, 0x8, 0xC.
  - Response: count=4, in_ready=0; a fifth push of pc 0x10 is ignored.
  - Then out_ready=1 for 4 cycles: pcs 0x0, 0x4, 0x8, 0xC emerge in order, then out_valid=0.
- Steady stream with wrap:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 10 cycles, pcs 0x0..0x24.
  - Response: count stays 1 after the first edge; outputs follow inputs by 1 cycle in order across pointer wrap.
- Flush:
  - Stimulus: count=3 (pcs 0x0, 0x4, 0x8); assert flush with in_valid=1 pc 0xC and out_ready=1.
  - Response: next cycle count=0, out_valid=0; pc 0xC is never output.
  - A following push of pc 0x40 appears as the next head.
- Reset priority:
  - Stimulus: reset and flush both high with count=2.
  - Response: count=0, in_ready=1, out_valid=0.
  - With FDQ_BUBBLE_NOP_EN: out_instruction=0xAA1F03FF and out_pc=0.
- Stall hold:
  - Stimulus: head pc 0x4, out_ready=0 for 5 cycles while pushing pc 0x8.
  - Response: out_pc stays 0x4 for all 5 cycles; count goes from 1 to 2.
